// File: rtl/signed_resize_pkg.sv
// Shared helpers for signed_resize_pipe: internal width calculation,
// saturation bounds and the lane index type.
package signed_resize_pkg;

   typedef logic [7:0] lane_idx_t;

   function automatic int abs_int(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Internal width: widest of in/out plus the shift magnitude plus two
   // guard bits (one for the rounding carry, one for the sign).
   function automatic int calc_internal_width(input int in_size, input int out_size,
                                              input int shift);
      return ((in_size > out_size) ? in_size : out_size) + abs_int(shift) + 2;
   endfunction

   // Largest two's complement value representable in w bits.
   function automatic logic signed [63:0] sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   // Smallest two's complement value representable in w bits.
   function automatic logic signed [63:0] sat_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/signed_resize_lane.sv
// Combinational per-lane datapath for signed_resize_pipe.
// Front half: sign-extend and scale by 2^shift (left or right).
// Back half: saturate the registered scaled value to out_size bits.
// Build option SIGNED_RESIZE_ROUND_EN: right shifts round half-up;
// without it right shifts truncate toward -inf and no adder is built.
module signed_resize_lane
   import signed_resize_pkg::*;
#(
   parameter int in_size  = 12,
   parameter int out_size = 16,
   parameter int shift    = 4,
   parameter int W        = calc_internal_width(in_size, out_size, shift)
) (
   input  logic [in_size-1:0]  in_word,
   output logic signed [W-1:0] scaled,
   input  logic signed [W-1:0] mid_value,
   output logic [out_size-1:0] sat_value,
   output logic                sat_ovf
);

   localparam logic signed [W-1:0] MAX_V = W'(sat_max(out_size));
   localparam logic signed [W-1:0] MIN_V = W'(sat_min(out_size));

   logic signed [W-1:0] ext;

   assign ext = {{(W - in_size){in_word[in_size-1]}}, in_word};

   generate
      if (shift > 0) begin : g_lsh
         assign scaled = ext <<< shift;
      end else if (shift < 0) begin : g_rsh
         localparam int RSH = -shift;
`ifdef SIGNED_RESIZE_ROUND_EN
         // Adding half an output LSB before the shift gives round-half-up;
         // the guard bit in W keeps the max-positive carry from wrapping.
         localparam logic signed [W-1:0] RND = W'(1) <<< (RSH - 1);
         assign scaled = (ext + RND) >>> RSH;
`else
         assign scaled = ext >>> RSH;
`endif
      end else begin : g_pass
         assign scaled = ext;
      end
   endgenerate

   // Clamp to the output range and flag when clamping happened.
   always_comb begin
      sat_ovf   = 1'b0;
      sat_value = mid_value[out_size-1:0];
      if (mid_value > MAX_V) begin
         sat_ovf   = 1'b1;
         sat_value = MAX_V[out_size-1:0];
      end else if (mid_value < MIN_V) begin
         sat_ovf   = 1'b1;
         sat_value = MIN_V[out_size-1:0];
      end
   end

endmodule

// File: rtl/signed_resize_pipe.sv
// Two-stage multi-channel signed resizer: extend/scale in stage 1,
// saturate in stage 2, valid/ready handshake with a single global enable,
// per-lane overflow and sticky overflow flags.
// Build option SIGNED_RESIZE_ROUND_EN selects rounding on right shifts
// (handled inside signed_resize_lane).
module signed_resize_pipe
   import signed_resize_pkg::*;
#(
   parameter int in_size      = 12,
   parameter int out_size     = 16,
   parameter int shift        = 4,
   parameter int num_channels = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [num_channels*in_size-1:0]  in_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [num_channels*out_size-1:0] out_data,
   output logic [num_channels-1:0]          out_ovf,
   output logic [num_channels-1:0]          ovf_sticky,
   input  logic                             ovf_clear
);

   localparam int W = calc_internal_width(in_size, out_size, shift);

   logic en;

   logic                                   s1_vld_q, s1_vld_d;
   logic [num_channels-1:0][W-1:0]         s1_val_q, s1_val_d;
   logic                                   out_valid_q, out_valid_d;
   logic [num_channels-1:0][out_size-1:0]  out_data_q, out_data_d;
   logic [num_channels-1:0]                ovf_q, ovf_d;
   logic [num_channels-1:0]                sticky_q, sticky_d;

   logic [num_channels-1:0][W-1:0]         scaled;
   logic [num_channels-1:0][out_size-1:0]  sat_val;
   logic [num_channels-1:0]                sat_ovf;

   // Whole pipe moves together; a stalled output freezes everything.
   assign en       = !out_valid_q || out_ready;
   assign in_ready = en;

   generate
      for (genvar k = 0; k < num_channels; k++) begin : g_lane
         signed_resize_lane #(
            .in_size  (in_size),
            .out_size (out_size),
            .shift    (shift),
            .W        (W)
         ) u_lane (
            .in_word   (in_data[k*in_size +: in_size]),
            .scaled    (scaled[k]),
            .mid_value (s1_val_q[k]),
            .sat_value (sat_val[k]),
            .sat_ovf   (sat_ovf[k])
         );
      end
   endgenerate

   // Pipeline advance: data registers only load when a real beat moves in.
   always_comb begin
      s1_vld_d    = s1_vld_q;
      s1_val_d    = s1_val_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      ovf_d       = ovf_q;
      if (en) begin
         s1_vld_d    = in_valid;
         out_valid_d = s1_vld_q;
         if (in_valid) s1_val_d = scaled;
         if (s1_vld_q) begin
            out_data_d = sat_val;
            ovf_d      = sat_ovf;
         end
      end
   end

   // Sticky flags: clear first, then OR in a transferring overflow so set wins.
   always_comb begin
      sticky_d = ovf_clear ? '0 : sticky_q;
      if (out_valid_q && out_ready) sticky_d = sticky_d | ovf_q;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q    <= 1'b0;
         s1_val_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         ovf_q       <= '0;
         sticky_q    <= '0;
      end else begin
         s1_vld_q    <= s1_vld_d;
         s1_val_q    <= s1_val_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         ovf_q       <= ovf_d;
         sticky_q    <= sticky_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_ovf    = ovf_q;
   assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_signed_resize_pipe.sv
// Scoreboard bench for signed_resize_pipe. Three instances share one
// handshake: A = 4 lanes 12->16 <<4, B = 1 lane 12->8 >>4 (fed lane 0),
// C = 1 lane 12->12 <<2 (fed lane 1, overflows often for sticky tests).
module tb_signed_resize_pipe;

`ifdef SIGNED_RESIZE_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic        ovf_clear = 1'b0;
   logic [47:0] a_in_data = '0;

   logic        a_in_ready, b_in_ready, c_in_ready;
   logic        a_out_valid, b_out_valid, c_out_valid;
   logic [63:0] a_out_data;
   logic [7:0]  b_out_data;
   logic [11:0] c_out_data;
   logic [3:0]  a_out_ovf, a_sticky;
   logic        b_out_ovf, b_sticky, c_out_ovf, c_sticky;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   signed_resize_pipe #(.in_size(12), .out_size(16), .shift(4), .num_channels(4)) u_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
      .out_ovf(a_out_ovf), .ovf_sticky(a_sticky), .ovf_clear(ovf_clear));

   signed_resize_pipe #(.in_size(12), .out_size(8), .shift(-4), .num_channels(1)) u_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(a_in_data[11:0]),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
      .out_ovf(b_out_ovf), .ovf_sticky(b_sticky), .ovf_clear(ovf_clear));

   signed_resize_pipe #(.in_size(12), .out_size(12), .shift(2), .num_channels(1)) u_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .in_data(a_in_data[23:12]),
      .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
      .out_ovf(c_out_ovf), .ovf_sticky(c_sticky), .ovf_clear(ovf_clear));

   typedef struct packed {
      logic [63:0] a_d;
      logic [3:0]  a_o;
      logic [7:0]  b_d;
      logic        b_o;
      logic [11:0] c_d;
      logic        c_o;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   int   pcnt = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: integer value, scale by 2^sh with plain arithmetic
   // (floor division for right shifts), clip to the output range.
   function automatic void model(input logic [11:0] raw, input int osz, input int sh,
                                 output logic [63:0] y, output bit o);
      longint v, d, q, mx, mn;
      v = longint'(raw);
      if (raw[11]) v = v - 4096;
      if (sh >= 0) v = v * (longint'(1) << sh);
      else begin
         d = longint'(1) << (-sh);
         if (RND) v = v + d / 2;
         q = v / d;
         if ((q * d != v) && (v < 0)) q = q - 1;
         v = q;
      end
      mx = (longint'(1) << (osz - 1)) - 1;
      mn = -mx - 1;
      o = 1'b0;
      if (v > mx) begin v = mx; o = 1'b1; end
      else if (v < mn) begin v = mn; o = 1'b1; end
      y = 64'(v) & ((64'd1 << osz) - 64'd1);
   endfunction

   task automatic push(input logic [47:0] d, input bit lat);
      exp_t e;
      logic [63:0] y;
      bit o;
      e = '0;
      for (int k = 0; k < 4; k++) begin
         model(d[k*12 +: 12], 16, 4, y, o);
         e.a_d[k*16 +: 16] = y[15:0];
         e.a_o[k] = o;
      end
      model(d[11:0], 8, -4, y, o);
      e.b_d = y[7:0]; e.b_o = o;
      model(d[23:12], 12, 2, y, o);
      e.c_d = y[11:0]; e.c_o = o;
      e.acc = cyc; e.lat = lat;
      sb.push_back(e);
   endtask

   function automatic bit pick(input int mode);
      bit r;
      if (mode == 0) r = 1'b1;
      else if (mode == 1) r = 1'($urandom % 2);
      else begin
         r = (pcnt % 3) == 0;
         pcnt++;
      end
      return r;
   endfunction

   task automatic drive(input bit v, input logic [47:0] d, input bit rdy, input bit clr,
                        input bit lat, output bit acc);
      @(negedge clk);
      in_valid = v; a_in_data = d; out_ready = rdy; ovf_clear = clr;
      #1;
      acc = v && a_in_ready;
      if (acc) push(d, lat);
   endtask

   task automatic send(input logic [47:0] d, input int mode);
      bit acc = 1'b0;
      int tries = 0;
      while (!acc && tries < 64) begin
         drive(1'b1, d, pick(mode), 1'b0, mode == 0, acc);
         tries++;
      end
      if (!acc) begin
         checks++; errors++;
         $display("FAIL accept_timeout: beat %0h not accepted after %0d cycles", d, tries);
      end
   endtask

   task automatic idle(input bit rdy, input bit clr);
      bit acc;
      drive(1'b0, '0, rdy, clr, 1'b0, acc);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin idle(1'b1, 1'b0); n++; end
      chk("drain_empty", 64'(sb.size()), 64'd0);
      idle(1'b1, 1'b0); idle(1'b1, 1'b0);
   endtask

   // Monitor: handshake rule, sticky model, stall stability, scoreboard pop.
   logic [3:0]  st_a = '0;
   logic        st_b = 1'b0, st_c = 1'b0;
   bit          stall = 1'b0;
   logic [63:0] h_a;
   logic [7:0]  h_b;
   logic [11:0] h_c;
   logic [5:0]  h_o;

   always @(negedge clk) begin
      #2;
      if (mon_en) begin
         exp_t e;
         logic [3:0] xa;
         logic xb, xc;
         xa = '0; xb = 1'b0; xc = 1'b0;
         chk("in_ready_a", 64'(a_in_ready), 64'(!a_out_valid || out_ready));
         chk("in_ready_b", 64'(b_in_ready), 64'(!b_out_valid || out_ready));
         chk("in_ready_c", 64'(c_in_ready), 64'(!c_out_valid || out_ready));
         chk("valid_lockstep", 64'({b_out_valid, c_out_valid}), 64'({a_out_valid, a_out_valid}));
         chk("sticky", 64'({a_sticky, b_sticky, c_sticky}), 64'({st_a, st_b, st_c}));
         if (stall) begin
            chk("stall_valid", 64'(a_out_valid), 64'd1);
            chk("stall_data_a", a_out_data, h_a);
            chk("stall_data_bc", 64'({b_out_data, c_out_data}), 64'({h_b, h_c}));
            chk("stall_ovf", 64'({a_out_ovf, b_out_ovf, c_out_ovf}), 64'(h_o));
         end
         stall = 1'b0;
         if (rst) begin
            st_a = '0; st_b = 1'b0; st_c = 1'b0;
         end else begin
            if (a_out_valid) chk("beat_expected", 64'(sb.size() != 0), 64'd1);
            if (a_out_valid && out_ready && sb.size() != 0) begin
               e = sb.pop_front();
               chk("data_a", a_out_data, e.a_d);
               chk("ovf_a", 64'(a_out_ovf), 64'(e.a_o));
               chk("data_b", 64'(b_out_data), 64'(e.b_d));
               chk("ovf_b", 64'(b_out_ovf), 64'(e.b_o));
               chk("data_c", 64'(c_out_data), 64'(e.c_d));
               chk("ovf_c", 64'(c_out_ovf), 64'(e.c_o));
               if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd2);
               xa = e.a_o; xb = e.b_o; xc = e.c_o;
            end else if (a_out_valid && !out_ready) begin
               stall = 1'b1;
               h_a = a_out_data; h_b = b_out_data; h_c = c_out_data;
               h_o = {a_out_ovf, b_out_ovf, c_out_ovf};
            end
            st_a = (ovf_clear ? 4'b0 : st_a) | xa;
            st_b = (ovf_clear ? 1'b0 : st_b) | xb;
            st_c = (ovf_clear ? 1'b0 : st_c) | xc;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] d;
      bit acc;
      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_valid", 64'({a_out_valid, b_out_valid, c_out_valid}), 64'd0);
      chk("rst_data_a", a_out_data, 64'd0);
      chk("rst_data_bc", 64'({b_out_data, c_out_data}), 64'd0);
      chk("rst_ovf", 64'({a_out_ovf, b_out_ovf, c_out_ovf}), 64'd0);
      chk("rst_sticky", 64'({a_sticky, b_sticky, c_sticky}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;

      // Directed corner values, ready held high
      send({12'hFFF, 12'h001, 12'h800, 12'h7FF}, 0);
      send({12'h000, 12'h000, 12'h000, 12'h800}, 0);
      send({12'h000, 12'h000, 12'h000, 12'h808}, 0);
      send({12'h000, 12'h7FF, 12'h000, 12'h7FF}, 0);
      send({12'h7FF, 12'h800, 12'hFFF, 12'h001}, 0);
      drain();

      // Exhaustive input sweep across the four lanes of A
      for (int i = 0; i < 1024; i++) begin
         for (int k = 0; k < 4; k++) d[k*12 +: 12] = 12'(i * 4 + k);
         send(d, 0);
      end
      drain();

      // Backpressure 1,0,0 pattern
      pcnt = 0;
      for (int i = 0; i < 8; i++) send(48'({$urandom(), $urandom()}), 2);
      drain();

      // Random traffic with random ready and input gaps
      for (int i = 0; i < 300; i++) begin
         if ($urandom % 4 == 0) idle(1'($urandom % 2), 1'b0);
         else send(48'({$urandom(), $urandom()}), 1);
      end
      drain();

      // Sticky: clear coinciding with an overflow transfer keeps the bit
      idle(1'b1, 1'b1);
      send({12'h000, 12'h000, 12'h7FF, 12'h000}, 0);
      send({12'h000, 12'h000, 12'h7FF, 12'h000}, 0);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b1);
      idle(1'b1, 1'b1);
      chk("sticky_set_wins", 64'(c_sticky), 64'd1);
      idle(1'b1, 1'b0);
      chk("sticky_cleared", 64'(c_sticky), 64'd0);
      drain();

      // Reset with two beats in flight
      send({12'h123, 12'h456, 12'h789, 12'hABC}, 0);
      send({12'h321, 12'h654, 12'h987, 12'hCBA}, 0);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ovf_clear = 1'b0;
      sb.delete();
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      #1;
      chk("post_rst_valid", 64'({a_out_valid, b_out_valid, c_out_valid}), 64'd0);
      chk("post_rst_data", a_out_data, 64'd0);
      repeat (4) idle(1'b1, 1'b0);
      send({12'h7FF, 12'h800, 12'h808, 12'hFFF}, 0);
      drain();

      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
